// File: rtl/mem_wait_stage_if.sv
// Handshake bundle for mem_wait_stage: upstream instruction channel and downstream result channel.
// The slave modport is the stage's view; master is the neighbouring-stage (or bench) view.
interface mem_wait_stage_if #(
   parameter int unsigned INSTR_W = 32
);
   logic [INSTR_W-1:0] instr_in;
   logic               branch_in;
   logic               in_valid;
   logic               in_ready;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] instr_output;
   logic               branch_value;

   modport master (
      output instr_in, branch_in, in_valid, out_ready,
      input  in_ready, out_valid, instr_output, branch_value
   );

   modport slave (
      input  instr_in, branch_in, in_valid, out_ready,
      output in_ready, out_valid, instr_output, branch_value
   );
endinterface

// File: rtl/mem_wait_stage.sv
// Memory-wait pipeline stage: holds one instruction for WAIT_CYCLES, squashes on branch-tag mismatch.
// Optional MEM_WAIT_HANDSHAKE_EN adds a mem_rdy input gating the WAIT->DONE exit.
module mem_wait_stage #(
   parameter int unsigned        INSTR_W     = 32,
   parameter int unsigned        WAIT_CYCLES = 1,
   parameter logic [INSTR_W-1:0] NOP_INSTR   = 32'hE1A00000
) (
   input  logic            clk,
   input  logic            rst,
   mem_wait_stage_if.slave bus,
   input  logic            branch_ref,
   input  logic            sel_stall,
   output logic            stall_req
`ifdef MEM_WAIT_HANDSHAKE_EN
   ,
   input  logic            mem_rdy
`endif
);

   localparam int unsigned CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [INSTR_W-1:0] instr_q, instr_nxt;
   logic               branch_q, branch_nxt;
   logic               capture;
   logic               squash;
   logic               mem_ok;
   logic               skip_wait;

`ifdef MEM_WAIT_HANDSHAKE_EN
   assign mem_ok    = mem_rdy;
   assign skip_wait = 1'b0;
`else
   assign mem_ok    = 1'b1;
   assign skip_wait = (WAIT_CYCLES == 0);
`endif

   assign bus.in_ready  = ~rst & ~sel_stall &
                          ((state == IDLE) | ((state == DONE) & bus.out_ready));
   assign bus.out_valid = ~rst & ~sel_stall & (state == DONE);
   assign stall_req     = bus.in_valid & ~bus.in_ready;

   assign capture = bus.in_valid & bus.in_ready;
   assign squash  = (state != IDLE) & (branch_q != branch_ref);

   assign bus.instr_output = instr_q;
   assign bus.branch_value = branch_q;

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      instr_nxt  = instr_q;
      branch_nxt = branch_q;
      if (!sel_stall) begin
         case (state)
            WAIT: begin
               if (squash) begin
                  state_nxt = DONE;
                  instr_nxt = NOP_INSTR;
               end else begin
                  if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                  if ((cnt <= CNT_W'(1)) && mem_ok) state_nxt = DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state_nxt = IDLE;
               else if (squash)   instr_nxt = NOP_INSTR;
            end
            default: ;
         endcase
         // capture covers both IDLE and the DONE back-to-back case, so it overrides the exit to IDLE
         if (capture) begin
            instr_nxt  = (bus.branch_in != branch_ref) ? NOP_INSTR : bus.instr_in;
            branch_nxt = bus.branch_in;
            cnt_nxt    = CNT_W'(WAIT_CYCLES);
            state_nxt  = skip_wait ? DONE : WAIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         instr_q  <= NOP_INSTR;
         branch_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         instr_q  <= instr_nxt;
         branch_q <= branch_nxt;
      end
   end

endmodule

// File: tb/tb_mem_wait_stage.sv
// Directed bench for mem_wait_stage: one DUT per WAIT_CYCLES setting, shared clock/reset/tag/freeze.
// Handshake-variant checks are built only when MEM_WAIT_HANDSHAKE_EN is defined.
module tb_mem_wait_stage;

   localparam logic [31:0] NOP = 32'hE1A00000;

   logic clk = 1'b0;
   logic rst;
   logic branch_ref;
   logic sel_stall;
   logic mem_rdy;
   logic stall0, stall1, stall2, stall3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_wait_stage_if #(.INSTR_W(32)) if0 ();
   mem_wait_stage_if #(.INSTR_W(32)) if1 ();
   mem_wait_stage_if #(.INSTR_W(32)) if2 ();
   mem_wait_stage_if #(.INSTR_W(32)) if3 ();

   mem_wait_stage #(.INSTR_W(32), .WAIT_CYCLES(0), .NOP_INSTR(NOP)) u0 (
`ifdef MEM_WAIT_HANDSHAKE_EN
      .mem_rdy(mem_rdy),
`endif
      .clk(clk), .rst(rst), .bus(if0.slave), .branch_ref(branch_ref),
      .sel_stall(sel_stall), .stall_req(stall0));

   mem_wait_stage #(.INSTR_W(32), .WAIT_CYCLES(1), .NOP_INSTR(NOP)) u1 (
`ifdef MEM_WAIT_HANDSHAKE_EN
      .mem_rdy(mem_rdy),
`endif
      .clk(clk), .rst(rst), .bus(if1.slave), .branch_ref(branch_ref),
      .sel_stall(sel_stall), .stall_req(stall1));

   mem_wait_stage #(.INSTR_W(32), .WAIT_CYCLES(2), .NOP_INSTR(NOP)) u2 (
`ifdef MEM_WAIT_HANDSHAKE_EN
      .mem_rdy(mem_rdy),
`endif
      .clk(clk), .rst(rst), .bus(if2.slave), .branch_ref(branch_ref),
      .sel_stall(sel_stall), .stall_req(stall2));

   mem_wait_stage #(.INSTR_W(32), .WAIT_CYCLES(3), .NOP_INSTR(NOP)) u3 (
`ifdef MEM_WAIT_HANDSHAKE_EN
      .mem_rdy(mem_rdy),
`endif
      .clk(clk), .rst(rst), .bus(if3.slave), .branch_ref(branch_ref),
      .sel_stall(sel_stall), .stall_req(stall3));

   // advance to 1 time unit past the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (if2.in_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_in_ready_held: got %b want 0", if2.in_ready);
      end
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (if2.instr_output !== NOP) begin
         n_bad++; $display("FAIL reset_instr: got %h want %h", if2.instr_output, NOP);
      end
      n_cmp++;
      if ({if2.out_valid, if2.in_ready, if2.branch_value, stall2} !== 4'b0100) begin
         n_bad++; $display("FAIL reset_ctrl {ov,ir,bv,sr}: got %b want 0100",
                           {if2.out_valid, if2.in_ready, if2.branch_value, stall2});
      end
   endtask

   task automatic test_capture();
      if2.instr_in = 32'hE0810002; if2.branch_in = 1'b0; if2.in_valid = 1'b1;
      tick();
      if2.in_valid = 1'b0;
      n_cmp++;
      if ({if2.out_valid, if2.in_ready} !== 2'b00) begin
         n_bad++; $display("FAIL capture_c1 {ov,ir}: got %b want 00", {if2.out_valid, if2.in_ready});
      end
      tick();
      n_cmp++;
      if (if2.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL capture_c2_valid: got %b want 0", if2.out_valid);
      end
      tick();
      n_cmp++;
      if (if2.out_valid !== 1'b1 || if2.instr_output !== 32'hE0810002 || if2.branch_value !== 1'b0) begin
         n_bad++; $display("FAIL capture_c3 ov/instr/bv: got %b/%h/%b want 1/e0810002/0",
                           if2.out_valid, if2.instr_output, if2.branch_value);
      end
      if2.out_ready = 1'b1;
      tick();
      if2.out_ready = 1'b0;
      n_cmp++;
      if ({if2.out_valid, if2.in_ready} !== 2'b01) begin
         n_bad++; $display("FAIL capture_drain {ov,ir}: got %b want 01", {if2.out_valid, if2.in_ready});
      end
   endtask

   task automatic test_mismatch();
      int waited;
      branch_ref = 1'b1;
      if2.instr_in = 32'hE5912000; if2.branch_in = 1'b0; if2.in_valid = 1'b1;
      tick();
      if2.in_valid = 1'b0;
      waited = 0;
      while (if2.out_valid !== 1'b1 && waited < 6) begin
         tick();
         waited++;
      end
      n_cmp++;
      if (if2.out_valid !== 1'b1 || if2.instr_output !== NOP) begin
         n_bad++; $display("FAIL mismatch_nop ov/instr: got %b/%h want 1/%h",
                           if2.out_valid, if2.instr_output, NOP);
      end
      if2.out_ready = 1'b1;
      tick();
      if2.out_ready = 1'b0;
      branch_ref = 1'b0;
   endtask

   task automatic test_late_squash();
      if3.instr_in = 32'hE0810002; if3.branch_in = 1'b0; if3.in_valid = 1'b1;
      tick();
      if3.in_valid = 1'b0;
      branch_ref = 1'b1;
      #1;
      n_cmp++;
      if (if3.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL squash_c1_valid: got %b want 0", if3.out_valid);
      end
      tick();
      n_cmp++;
      if (if3.out_valid !== 1'b1 || if3.instr_output !== NOP || if3.branch_value !== 1'b0) begin
         n_bad++; $display("FAIL squash_c2 ov/instr/bv: got %b/%h/%b want 1/%h/0",
                           if3.out_valid, if3.instr_output, if3.branch_value, NOP);
      end
      if3.out_ready = 1'b1;
      branch_ref = 1'b0;
      tick();
      if3.out_ready = 1'b0;
   endtask

`ifndef MEM_WAIT_HANDSHAKE_EN
   task automatic test_back_to_back();
      if0.instr_in = 32'hE0811002; if0.branch_in = 1'b0; if0.in_valid = 1'b1; if0.out_ready = 1'b0;
      tick();
      if0.instr_in = 32'hE0822003;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (if0.out_valid !== 1'b1 || if0.instr_output !== 32'hE0811002 || stall0 !== 1'b1) begin
            n_bad++; $display("FAIL hold_%0d ov/instr/stall: got %b/%h/%b want 1/e0811002/1",
                              i, if0.out_valid, if0.instr_output, stall0);
         end
         tick();
      end
      if0.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (if0.in_ready !== 1'b1 || stall0 !== 1'b0) begin
         n_bad++; $display("FAIL b2b_accept ir/stall: got %b/%b want 1/0", if0.in_ready, stall0);
      end
      tick();
      n_cmp++;
      if (if0.out_valid !== 1'b1 || if0.instr_output !== 32'hE0822003) begin
         n_bad++; $display("FAIL b2b_second ov/instr: got %b/%h want 1/e0822003",
                           if0.out_valid, if0.instr_output);
      end
      if0.instr_in = 32'hE0833004;
      tick();
      n_cmp++;
      if (if0.out_valid !== 1'b1 || if0.instr_output !== 32'hE0833004) begin
         n_bad++; $display("FAIL b2b_third ov/instr: got %b/%h want 1/e0833004",
                           if0.out_valid, if0.instr_output);
      end
      if0.in_valid = 1'b0;
      tick();
      if0.out_ready = 1'b0;
      n_cmp++;
      if (if0.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL b2b_empty_valid: got %b want 0", if0.out_valid);
      end
   endtask
`endif

   task automatic test_sel_stall();
      if2.instr_in = 32'hE0844005; if2.branch_in = 1'b0; if2.in_valid = 1'b1;
      tick();
      if2.in_valid = 1'b0;
      sel_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({if2.out_valid, if2.in_ready} !== 2'b00) begin
            n_bad++; $display("FAIL frozen_%0d {ov,ir}: got %b want 00", i, {if2.out_valid, if2.in_ready});
         end
         tick();
      end
      sel_stall = 1'b0;
      tick();
      n_cmp++;
      if (if2.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL frozen_early_valid: got %b want 0", if2.out_valid);
      end
      tick();
      n_cmp++;
      if (if2.out_valid !== 1'b1 || if2.instr_output !== 32'hE0844005) begin
         n_bad++; $display("FAIL frozen_late ov/instr: got %b/%h want 1/e0844005",
                           if2.out_valid, if2.instr_output);
      end
      sel_stall = 1'b1;
      #1;
      n_cmp++;
      if (if2.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL frozen_done_valid: got %b want 0", if2.out_valid);
      end
      sel_stall = 1'b0;
      if2.out_ready = 1'b1;
      tick();
      if2.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      if2.instr_in = 32'hE0855006; if2.branch_in = 1'b0; if2.in_valid = 1'b1;
      tick();
      if2.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (if2.instr_output !== NOP || if2.out_valid !== 1'b0 || if2.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_mid instr/ov/ir: got %h/%b/%b want %h/0/1",
                           if2.instr_output, if2.out_valid, if2.in_ready, NOP);
      end
      tick();
      tick();
      n_cmp++;
      if (if2.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid_stays_idle: got %b want 0", if2.out_valid);
      end
   endtask

`ifdef MEM_WAIT_HANDSHAKE_EN
   task automatic test_mem_handshake();
      mem_rdy = 1'b0;
      if1.instr_in = 32'hE0866007; if1.branch_in = 1'b0; if1.in_valid = 1'b1;
      tick();
      if1.in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++;
         if (if1.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL memwait_%0d_valid: got %b want 0", i, if1.out_valid);
         end
         tick();
      end
      mem_rdy = 1'b1;
      tick();
      n_cmp++;
      if (if1.out_valid !== 1'b1 || if1.instr_output !== 32'hE0866007) begin
         n_bad++; $display("FAIL memwait_done ov/instr: got %b/%h want 1/e0866007",
                           if1.out_valid, if1.instr_output);
      end
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; branch_ref = 1'b0; sel_stall = 1'b0; mem_rdy = 1'b1;
      if0.instr_in = '0; if0.branch_in = 1'b0; if0.in_valid = 1'b0; if0.out_ready = 1'b0;
      if1.instr_in = '0; if1.branch_in = 1'b0; if1.in_valid = 1'b0; if1.out_ready = 1'b0;
      if2.instr_in = '0; if2.branch_in = 1'b0; if2.in_valid = 1'b0; if2.out_ready = 1'b0;
      if3.instr_in = '0; if3.branch_in = 1'b0; if3.in_valid = 1'b0; if3.out_ready = 1'b0;
      test_reset();
      tick();
      test_capture();
      test_mismatch();
      test_late_squash();
`ifndef MEM_WAIT_HANDSHAKE_EN
      test_back_to_back();
`endif
      test_sel_stall();
      test_reset_mid();
`ifdef MEM_WAIT_HANDSHAKE_EN
      test_mem_handshake();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_wait_stage.md
# mem_wait_stage

Parametrised memory-wait pipeline stage for the ARM32 pipeline. It sits between the memory-issue and writeback stages and holds one instruction for a configurable number of wait cycles. It squashes the held instruction to a NOP on a branch-tag mismatch and exchanges valid/ready handshakes with its neighbours. It raises a stall request upstream while occupied.

## Interface

Parameters:
- INSTR_W, 32, instruction width in bits.
- WAIT_CYCLES, 1, minimum wait cycles per instruction; legal range 0..15.
- NOP_INSTR, 32'hE1A00000, value substituted for squashed or empty slots (MOV r0,r0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_in  input  INSTR_W  incoming instruction.
- branch_in  input  1  branch tag carried by instr_in.
- branch_ref  input  1  current architectural branch tag.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage accepts instr_in this cycle.
- sel_stall  input  1  global freeze from the hazard unit.
- out_valid  output  1  instr_output is valid for downstream.
- out_ready  input  1  downstream accepts.
- instr_output  output  INSTR_W  held instruction.
- branch_value  output  1  branch tag of the held instruction.
- stall_req  output  1  equals in_valid & ~in_ready.
- mem_rdy  input  1  memory completion. Present only with MEM_WAIT_HANDSHAKE_EN.

## Operation

- State register: IDLE, WAIT, DONE.
- Wait counter width is $clog2(WAIT_CYCLES+1). The counter saturates at 0 and never wraps.
- Capture occurs when in_valid & in_ready & ~sel_stall.
  - If branch_in != branch_ref, the stage stores NOP_INSTR; otherwise it stores instr_in.
  - branch_value takes branch_in.
  - The counter loads WAIT_CYCLES.
  - Next state is WAIT, or DONE when WAIT_CYCLES==0.
- IDLE:
  - in_ready=1, out_valid=0.
- WAIT:
  - in_ready=0.
  - The counter decrements each unfrozen cycle.
  - The stage moves to DONE on the edge where the counter equals 1, or where it is already 0.
- DONE:
  - out_valid=~sel_stall.
  - in_ready = out_ready & ~sel_stall.
  - On out_ready with a simultaneous capture, the stage loads the new instruction back-to-back with no bubble.
  - On out_ready without a capture, the stage returns to IDLE.
  - Otherwise it holds.
- Late squash: in WAIT or DONE, if branch_value != branch_ref:
  - instr_output becomes NOP_INSTR on the next edge.
  - A WAIT state goes directly to DONE on that edge.
  - branch_value is unchanged.
- sel_stall=1 freezes everything:
  - no capture, no count, no transition, no squash;
  - in_ready=0 and out_valid=0.
- Reset values:
  - state IDLE, counter 0;
  - instr_output=NOP_INSTR, branch_value=0;
  - out_valid=0, in_ready=1 (held at 0 while rst is asserted), stall_req=0.
- Reset mid-operation discards the held instruction. No output handshake completes in the reset cycle.

## Timing

- Capture in cycle c means out_valid is first high in cycle c+1+WAIT_CYCLES, with no sel_stall and no handshake gating. Each frozen cycle adds one cycle.
- Sustained throughput is one instruction per WAIT_CYCLES+1 cycles. With WAIT_CYCLES==0 the throughput is one per cycle.
- All outputs are registered except in_ready, out_valid and stall_req. These are combinational from state, sel_stall and out_ready.
- A late squash takes effect the cycle after branch_ref changes.

## Configuration

- MEM_WAIT_HANDSHAKE_EN defined:
  - The mem_rdy port exists.
  - The WAIT→DONE transition additionally requires mem_rdy=1.
  - With WAIT_CYCLES==0, capture enters WAIT (counter 0) and the stage leaves on the first mem_rdy. Minimum latency is therefore one cycle more.
  - A late squash still exits WAIT without mem_rdy.
- Undefined:
  - No mem_rdy port.
  - Latency is fixed by WAIT_CYCLES alone.

## Test plan

- Reset, then WAIT_CYCLES=2: capture 32'hE0810002 with branch_in=branch_ref=0 in cycle 5 -> out_valid high in cycle 8, instr_output=32'hE0810002, branch_value=0.
- Mismatched tag: branch_ref=1, branch_in=0, instr 32'hE5912000 -> instr_output=32'hE1A00000 when out_valid rises.
- Late squash: branch_ref toggles one cycle after capture with WAIT_CYCLES=3 -> NOP_INSTR appears and out_valid rises the next cycle (early exit).
- Back-pressure and back-to-back, WAIT_CYCLES=0:
  - out_ready=0 for 4 cycles -> output held stable and stall_req=1 while in_valid=1.
  - Then out_ready=1 with in_valid=1 -> next instruction visible the following cycle with no bubble.
- sel_stall=1 for 3 cycles mid-WAIT -> counter frozen, out_valid delayed exactly 3 cycles; rst asserted mid-WAIT -> IDLE, instr_output=32'hE1A00000 next cycle.
- With MEM_WAIT_HANDSHAKE_EN, WAIT_CYCLES=1 and mem_rdy low 5 cycles after the counter expires -> out_valid rises the cycle after mem_rdy=1.
